popcount_frame_acc: RTL and testbench

Streaming accumulator placed directly downstream of the combinational popcount stage. Each beat carries one word's set-bit count (0..DATA_W); the block sums counts and beats over a frame delimited by `in_last`, then presents the frame total on a registered valid/ready output. It supplies per-frame bit-density totals to downstream consumers and applies backpressure upstream while a result is unconsumed.

---
 rtl/popcount_frame_acc.sv | 117 +++++++++++
 tb/tb_popcount_frame_acc.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_frame_acc.sv
// popcount_frame_acc: sums per-word popcounts and beat counts over a frame
// closed by in_last, and presents the saturating frame totals through a
// one-entry registered valid/ready output buffer.
module popcount_frame_acc #(
  parameter int DATA_W  = 10,
  parameter int CNT_W   = $clog2(DATA_W + 1),
  parameter int ACC_W   = 16,
  parameter int WORDS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   in_count,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [ACC_W-1:0]   out_total,
  output logic [WORDS_W-1:0] out_words,
  output logic               out_sat,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [WORDS_W-1:0] words;
  logic               sat;

  logic               beat_acc;
  logic               out_hs;
  logic [CNT_W-1:0]   count_clamped;
  logic [ACC_W-1:0]   acc_base;
  logic [WORDS_W-1:0] words_base;
  logic               sat_base;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   acc_next;
  logic               acc_ovf;
  logic [WORDS_W-1:0] words_next;
  logic               words_ovf;
  logic               sat_next;

  // The output buffer frees up in the same cycle it is drained, so a new
  // last beat can land on the handshake cycle without a bubble.
  assign in_ready = ~out_valid | out_ready;
  assign beat_acc = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  // Clamp the incoming count, then form the saturating next totals.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    count_clamped = in_count;
    if (in_count > CNT_W'(DATA_W)) begin
      count_clamped = CNT_W'(DATA_W);
    end

    // In IDLE the open frame is empty, so the running state is treated as zero.
    acc_base   = (state == IDLE) ? '0 : acc;
    words_base = (state == IDLE) ? '0 : words;
    sat_base   = (state == IDLE) ? 1'b0 : sat;

    // One extra bit catches the carry; the sum then clamps instead of wrapping.
    sum_wide = {1'b0, acc_base} + (ACC_W + 1)'(count_clamped);
    acc_ovf  = sum_wide[ACC_W];
    acc_next = acc_ovf ? '1 : sum_wide[ACC_W-1:0];

    words_ovf  = (words_base == '1);
    words_next = words_ovf ? words_base : words_base + WORDS_W'(1);

    sat_next = sat_base | acc_ovf | words_ovf;
  end

  // Frame FSM, running accumulators and the registered output buffer.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      words     <= '0;
      sat       <= 1'b0;
      out_total <= '0;
      out_words <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_hs) begin
        out_valid <= 1'b0;
      end

      if (beat_acc) begin
        if (in_last) begin
          // Closing beat: publish the frame and reopen an empty one. This
          // overrides the drain above on a simultaneous handshake.
          out_total <= acc_next;
          out_words <= words_next;
          out_sat   <= sat_next;
          out_valid <= 1'b1;
          acc       <= '0;
          words     <= '0;
          sat       <= 1'b0;
          state     <= IDLE;
        end else begin
          acc   <= acc_next;
          words <= words_next;
          sat   <= sat_next;
          state <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Self-checking bench for popcount_frame_acc. Two instances share one
// stimulus stream: the default configuration and a narrow ACC_W=5 one that
// exercises total saturation. A scoreboard of expected frame results is
// filled as beats are accepted and drained on output handshakes.
module tb_popcount_frame_acc;

  localparam int DATA_W  = 10;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int ACC_W   = 16;
  localparam int ACC_W_S = 5;
  localparam int WORDS_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [CNT_W-1:0]   in_count;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [ACC_W-1:0]   out_total;
  logic [WORDS_W-1:0] out_words;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;

  logic               s_in_ready;
  logic [ACC_W_S-1:0] s_out_total;
  logic [WORDS_W-1:0] s_out_words;
  logic               s_out_sat;
  logic               s_out_valid;

  typedef struct {
    int unsigned total;
    int unsigned total_s;
    int unsigned words;
    bit          sat;
    bit          sat_s;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_sum;
  int unsigned m_words;
  int          total_checks = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  popcount_frame_acc #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .WORDS_W(WORDS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_count(in_count), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_total(out_total),
    .out_words(out_words), .out_sat(out_sat), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  popcount_frame_acc #(
    .DATA_W(DATA_W), .ACC_W(ACC_W_S), .WORDS_W(WORDS_W)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .in_count(in_count), .in_valid(in_valid),
    .in_last(in_last), .in_ready(s_in_ready), .out_total(s_out_total),
    .out_words(s_out_words), .out_sat(s_out_sat), .out_valid(s_out_valid),
    .out_ready(out_ready)
  );

  // Scoreboard: compare on output handshakes, model accepted beats.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned c;
    if (!rst_n) begin
      m_sum   = 0;
      m_words = 0;
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        total_checks++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: result total=%0d words=%0d with nothing expected",
                   out_total, out_words);
        end else begin
          e = sb.pop_front();
          if (out_total !== ACC_W'(e.total) || out_words !== WORDS_W'(e.words) ||
              out_sat !== e.sat || s_out_total !== ACC_W_S'(e.total_s) ||
              s_out_words !== WORDS_W'(e.words) || s_out_sat !== e.sat_s) begin
            bad++;
            $display("FAIL sb_result: got total=%0d words=%0d sat=%0b s_total=%0d s_words=%0d s_sat=%0b, want total=%0d words=%0d sat=%0b s_total=%0d s_sat=%0b",
                     out_total, out_words, out_sat, s_out_total, s_out_words, s_out_sat,
                     e.total, e.words, e.sat, e.total_s, e.sat_s);
          end
        end
      end

      total_checks++;
      if (s_out_valid !== out_valid || s_in_ready !== in_ready) begin
        bad++;
        $display("FAIL inst_agree: valid=%0b/%0b ready=%0b/%0b",
                 out_valid, s_out_valid, in_ready, s_in_ready);
      end

      if (in_valid && in_ready) begin
        c = (in_count > CNT_W'(DATA_W)) ? DATA_W : int'(in_count);
        m_sum   += c;
        m_words += 1;
        if (in_last) begin
          e.total   = (m_sum > 65535) ? 65535 : m_sum;
          e.total_s = (m_sum > 31) ? 31 : m_sum;
          e.words   = (m_words > 255) ? 255 : m_words;
          e.sat     = (m_sum > 65535) || (m_words > 255);
          e.sat_s   = (m_sum > 31) || (m_words > 255);
          sb.push_back(e);
          m_sum   = 0;
          m_words = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_count = '0;
  endtask

  // Present one beat and return just after the edge that accepts it;
  // in_valid is left high so beats can follow back to back.
  task automatic send_beat(input int c, input bit last);
    int waits = 0;
    in_valid = 1'b1;
    in_count = CNT_W'(c);
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total_checks++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, waits);
    end
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_count  = CNT_W'(9);
    in_last   = 1'b1;
    repeat (2) step();
    idle_in();
    rst_n = 1'b1;
    @(negedge clk);
    total_checks++;
    if (out_valid !== 1'b0 || out_total !== '0 || out_words !== '0 ||
        out_sat !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: valid=%0b total=%0d words=%0d sat=%0b in_ready=%0b, want 0 0 0 0 1",
               out_valid, out_total, out_words, out_sat, in_ready);
    end
    step();
  endtask

  task automatic test_defaults();
    out_ready = 1'b1;
    send_beat(3, 1'b0);
    send_beat(10, 1'b0);
    send_beat(0, 1'b1);
    idle_in();
    @(negedge clk);
    total_checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd13 || out_words !== 8'd3 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL defaults_result: valid=%0b total=%0d words=%0d sat=%0b, want 1 13 3 0",
               out_valid, out_total, out_words, out_sat);
    end
    @(negedge clk);
    total_checks++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL defaults_one_cycle: valid=%0b, want 0", out_valid);
    end
    step();
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    send_beat(7, 1'b1);
    in_count = CNT_W'(2);
    in_last  = 1'b1;
    @(negedge clk);
    total_checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd7 || out_words !== 8'd1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_first: valid=%0b total=%0d words=%0d in_ready=%0b, want 1 7 1 1",
               out_valid, out_total, out_words, in_ready);
    end
    step();
    idle_in();
    @(negedge clk);
    total_checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd2 || out_words !== 8'd1) begin
      bad++;
      $display("FAIL single_second: valid=%0b total=%0d words=%0d, want 1 2 1",
               out_valid, out_total, out_words);
    end
    @(negedge clk);
    total_checks++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: valid=%0b, want 0", out_valid);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(5, 1'b0);
    send_beat(5, 1'b1);
    in_count = CNT_W'(4);
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_total !== 16'd10) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: in_ready=%0b valid=%0b total=%0d, want 0 1 10",
                 i, in_ready, out_valid, out_total);
      end
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    total_checks++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: in_ready=%0b, want 1", in_ready);
    end
    step();
    idle_in();
    @(negedge clk);
    total_checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd4 || out_words !== 8'd1) begin
      bad++;
      $display("FAIL bp_pending_beat: valid=%0b total=%0d words=%0d, want 1 4 1",
               out_valid, out_total, out_words);
    end
    step();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(10, 1'b0);
    send_beat(10, 1'b1);
    idle_in();
    @(negedge clk);
    total_checks++;
    if (s_out_total !== 5'd31 || s_out_words !== 8'd4 || s_out_sat !== 1'b1 ||
        out_total !== 16'd40 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL sat_frame: s_total=%0d s_words=%0d s_sat=%0b total=%0d sat=%0b, want 31 4 1 40 0",
               s_out_total, s_out_words, s_out_sat, out_total, out_sat);
    end
    step();
    send_beat(1, 1'b1);
    idle_in();
    @(negedge clk);
    total_checks++;
    if (s_out_total !== 5'd1 || s_out_sat !== 1'b0) begin
      bad++;
      $display("FAIL sat_clear: s_total=%0d s_sat=%0b, want 1 0", s_out_total, s_out_sat);
    end
    step();
  endtask

  task automatic test_words_sat();
    out_ready = 1'b1;
    for (int i = 0; i < 299; i++) send_beat(0, 1'b0);
    send_beat(0, 1'b1);
    idle_in();
    @(negedge clk);
    total_checks++;
    if (out_words !== 8'd255 || out_sat !== 1'b1 || out_total !== 16'd0) begin
      bad++;
      $display("FAIL words_sat: words=%0d sat=%0b total=%0d, want 255 1 0",
               out_words, out_sat, out_total);
    end
    step();
  endtask

  task automatic test_clamp();
    out_ready = 1'b1;
    send_beat(15, 1'b1);
    idle_in();
    @(negedge clk);
    total_checks++;
    if (out_total !== 16'd10 || out_words !== 8'd1) begin
      bad++;
      $display("FAIL clamp: total=%0d words=%0d, want 10 1", out_total, out_words);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_beat(4, 1'b0);
    send_beat(6, 1'b0);
    idle_in();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total_checks++;
    if (out_valid !== 1'b0 || out_total !== '0 || out_words !== '0 ||
        out_sat !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_state: valid=%0b total=%0d words=%0d sat=%0b in_ready=%0b, want 0 0 0 0 1",
               out_valid, out_total, out_words, out_sat, in_ready);
    end
    step();
    send_beat(5, 1'b1);
    idle_in();
    @(negedge clk);
    total_checks++;
    if (out_total !== 16'd5 || out_words !== 8'd1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_frame: total=%0d words=%0d valid=%0b, want 5 1 1",
               out_total, out_words, out_valid);
    end
    step();
  endtask

  // Random traffic with random consumer stalls; upstream holds a stalled beat.
  task automatic test_random();
    bit stalled = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_count = CNT_W'($urandom_range(0, 15));
        in_last  = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      stalled = in_valid && !in_ready;
      step();
    end
    idle_in();
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    total_checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain: pending=%0d valid=%0b, want 0 0", sb.size(), out_valid);
    end
    step();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_defaults();
    test_single_beat();
    test_backpressure();
    test_saturation();
    test_words_sat();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total_checks, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
